// File: rtl/edge_stream.sv
`default_nettype none
// ============================================================================
// edge_stream : streaming 3x3 Sobel edge detector, raster order in and out
// Rev 1.0
// ============================================================================
module edge_stream #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int PIX_W  = 4,
  parameter int ADDR_W = $clog2(WIDTH*HEIGHT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sof,
  input  logic [PIX_W-1:0]  pixel_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        mode,
  input  logic [PIX_W+2:0]  thresh,
  output logic [11:0]       data_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] addr,
  output logic              frame_done
);

  localparam int c_col_w  = $clog2(WIDTH);
  localparam int c_row_w  = (HEIGHT > 2) ? $clog2(HEIGHT) : 1;
  localparam int c_fill_w = $clog2(WIDTH+2);
  localparam int c_sum_w  = PIX_W + 4;
  localparam int c_mag_w  = PIX_W + 3;

  localparam logic [c_col_w-1:0]  c_col_last  = c_col_w'(WIDTH-1);
  localparam logic [c_row_w-1:0]  c_row_last  = c_row_w'(HEIGHT-1);
  localparam logic [c_fill_w-1:0] c_fill_full = c_fill_w'(WIDTH+1);
  localparam logic [ADDR_W-1:0]   c_last_idx  = ADDR_W'(WIDTH*HEIGHT-1);
  localparam logic [ADDR_W:0]     c_n_cnt     = (ADDR_W+1)'(WIDTH*HEIGHT);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FLUSH = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t               r_state;
  logic                 r_armed;
  logic [1:0]           r_mode;
  logic [PIX_W+2:0]     r_thresh;
  logic [ADDR_W-1:0]    r_in_idx;
  logic [c_col_w-1:0]   r_in_col;
  logic [c_fill_w-1:0]  r_fill;
  logic [ADDR_W:0]      r_load_cnt;
  logic [c_row_w-1:0]   r_out_row;
  logic [c_col_w-1:0]   r_out_col;

  logic [PIX_W-1:0]     r_lb1 [WIDTH];
  logic [PIX_W-1:0]     r_lb2 [WIDTH];
  logic [PIX_W-1:0]     r_wl  [3];
  logic [PIX_W-1:0]     r_wm  [3];

  logic                 w_free, w_accept, w_inject, w_adv, w_load;
  logic [c_col_w-1:0]   w_col;
  logic [PIX_W-1:0]     w_pix;
  logic [PIX_W-1:0]     w_new [3];
  logic [PIX_W-1:0]     w_a   [3][3];
  logic [c_sum_w-1:0]   w_sl, w_sr, w_st, w_sb;
  logic signed [c_sum_w-1:0] w_gx, w_gy;
  logic [c_mag_w-1:0]   w_agx, w_agy, w_mag;
  logic [3:0]           w_ch;
  logic [11:0]          w_pixel_out;

  assign w_free     = !out_valid || out_ready;
  assign in_ready   = r_armed && (r_state == S_RUN) && w_free;
  assign frame_done = (r_state == S_DONE);
  assign w_accept   = in_valid && in_ready;
  // Flush injects zero pixels until every output of the frame has been loaded.
  assign w_inject   = (r_state == S_FLUSH) && w_free && !sof && (r_load_cnt != c_n_cnt);
  assign w_adv      = w_accept || w_inject;
  assign w_load     = w_adv && !sof && (r_fill == c_fill_full);
  assign w_col      = sof ? '0 : r_in_col;
  assign w_pix      = w_inject ? '0 : pixel_in;

  // Window columns: left/middle come from the two previous advances, right is
  // the column being written now; frame-edge taps are zeroed by output position.
  always_comb begin
    w_new[0] = r_lb2[w_col];
    w_new[1] = r_lb1[w_col];
    w_new[2] = w_pix;
    for (int k = 0; k < 3; k++) begin
      w_a[k][0] = r_wl[k];
      w_a[k][1] = r_wm[k];
      w_a[k][2] = w_new[k];
    end
    for (int k = 0; k < 3; k++) begin
      if (r_out_row == '0)        w_a[0][k] = '0;
      if (r_out_row == c_row_last) w_a[2][k] = '0;
      if (r_out_col == '0)        w_a[k][0] = '0;
      if (r_out_col == c_col_last) w_a[k][2] = '0;
    end
  end

  assign w_sl = c_sum_w'(w_a[0][0]) + (c_sum_w'(w_a[1][0]) << 1) + c_sum_w'(w_a[2][0]);
  assign w_sr = c_sum_w'(w_a[0][2]) + (c_sum_w'(w_a[1][2]) << 1) + c_sum_w'(w_a[2][2]);
  assign w_st = c_sum_w'(w_a[0][0]) + (c_sum_w'(w_a[0][1]) << 1) + c_sum_w'(w_a[0][2]);
  assign w_sb = c_sum_w'(w_a[2][0]) + (c_sum_w'(w_a[2][1]) << 1) + c_sum_w'(w_a[2][2]);
  assign w_gx = $signed(w_sr - w_sl);
  assign w_gy = $signed(w_sb - w_st);
  assign w_agx = c_mag_w'(w_gx[c_sum_w-1] ? -w_gx : w_gx);
  assign w_agy = c_mag_w'(w_gy[c_sum_w-1] ? -w_gy : w_gy);

  always_comb begin
    case (r_mode)
      2'd1:    w_mag = w_agx + w_agy;
      2'd2:    w_mag = w_agx;
      2'd3:    w_mag = w_agy;
      default: w_mag = '0;
    endcase
    w_ch = 4'(w_mag >> (PIX_W-1));
    if (r_mode == 2'd0)
      w_pixel_out = ((w_agx > r_thresh) || (w_agy > r_thresh)) ? 12'hFFF : 12'h000;
    else
      w_pixel_out = {w_ch, w_ch, w_ch};
  end

  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_lb2[w_col] <= r_lb1[w_col];
      r_lb1[w_col] <= w_pix;
      r_wl         <= r_wm;
      r_wm         <= w_new;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_RUN;
      r_armed    <= 1'b0;
      r_mode     <= '0;
      r_thresh   <= '0;
      r_in_idx   <= '0;
      r_in_col   <= '0;
      r_fill     <= '0;
      r_load_cnt <= '0;
      r_out_row  <= '0;
      r_out_col  <= '0;
      out_valid  <= 1'b0;
      data_out   <= '0;
      addr       <= '0;
    end else begin
      r_armed <= 1'b1;
      if (!r_armed || sof) begin
        r_mode   <= mode;
        r_thresh <= thresh;
      end
      if (sof) begin
        // A pixel accepted alongside sof is pixel 0 of the new frame.
        r_state    <= S_RUN;
        out_valid  <= 1'b0;
        r_load_cnt <= '0;
        r_out_row  <= '0;
        r_out_col  <= '0;
        r_in_idx   <= w_accept ? ADDR_W'(1)   : '0;
        r_in_col   <= w_accept ? c_col_w'(1)  : '0;
        r_fill     <= w_accept ? c_fill_w'(1) : '0;
      end else begin
        if (w_adv) begin
          r_in_col <= (r_in_col == c_col_last) ? '0 : r_in_col + 1'b1;
          if (r_fill != c_fill_full)
            r_fill <= r_fill + 1'b1;
        end
        if (w_accept) begin
          r_in_idx <= r_in_idx + 1'b1;
          if (r_in_idx == c_last_idx)
            r_state <= S_FLUSH;
        end
        if (w_load) begin
          out_valid  <= 1'b1;
          data_out   <= w_pixel_out;
          addr       <= r_load_cnt[ADDR_W-1:0];
          r_load_cnt <= r_load_cnt + 1'b1;
          if (r_out_col == c_col_last) begin
            r_out_col <= '0;
            r_out_row <= r_out_row + 1'b1;
          end else begin
            r_out_col <= r_out_col + 1'b1;
          end
        end else if (out_ready) begin
          out_valid <= 1'b0;
        end
        if ((r_state == S_FLUSH) && out_valid && out_ready && (addr == c_last_idx))
          r_state <= S_DONE;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_edge_stream.sv
`default_nettype none
// tb_edge_stream : directed bench for edge_stream on 8x4 frames, checked
// against an arithmetic Sobel model plus hand-computed pixel values.
module tb_edge_stream;
  localparam int W  = 8;
  localparam int H  = 4;
  localparam int N  = W*H;
  localparam int P  = 4;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          sof = 1'b0;
  logic [P-1:0]  pixel_in = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    mode = 2'd1;
  logic [P+2:0]  thresh = '0;
  logic [11:0]   data_out;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [AW-1:0] addr;
  logic          frame_done;

  always #5 clk = ~clk;

  edge_stream #(.WIDTH(W), .HEIGHT(H), .PIX_W(P), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .sof(sof), .pixel_in(pixel_in),
    .in_valid(in_valid), .in_ready(in_ready), .mode(mode), .thresh(thresh),
    .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready),
    .addr(addr), .frame_done(frame_done)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [11:0]   d;
  } exp_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          img [N];
  exp_t        exp_q [$];
  logic [11:0] got [N];
  logic [11:0] got_ref [N];
  int          n_cons = 0;
  bit          mon_en = 1'b0;
  bit          stall_en = 1'b0;

  task automatic chk(input string name, input bit ok, input int act, input int req);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic int px(int r, int c);
    if (r < 0 || r >= H || c < 0 || c >= W) return 0;
    return img[r*W + c];
  endfunction

  function automatic logic [11:0] model(int o, int md, int th);
    int r = o / W;
    int c = o % W;
    int gx, gy, ax, ay, m;
    logic [3:0] ch;
    gx = (px(r-1,c+1) + 2*px(r,c+1) + px(r+1,c+1)) - (px(r-1,c-1) + 2*px(r,c-1) + px(r+1,c-1));
    gy = (px(r+1,c-1) + 2*px(r+1,c) + px(r+1,c+1)) - (px(r-1,c-1) + 2*px(r-1,c) + px(r-1,c+1));
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    if (md == 0) return (ax > th || ay > th) ? 12'hFFF : 12'h000;
    m  = (md == 1) ? ax + ay : (md == 2) ? ax : ay;
    ch = 4'(m >> (P-1));
    return {ch, ch, ch};
  endfunction

  task automatic set_flat(input int v);
    for (int k = 0; k < N; k++) img[k] = v;
  endtask

  task automatic set_step();
    for (int k = 0; k < N; k++) img[k] = ((k % W) >= 4) ? 15 : 0;
  endtask

  task automatic load_exp(input int md, input int th);
    for (int o = 0; o < N; o++) exp_q.push_back('{a: AW'(o), d: model(o, md, th)});
  endtask

  task automatic pulse_sof(input int md, input int th);
    mode = 2'(md);
    thresh = 7'(th);
    sof = 1'b1;
    @(posedge clk); #1;
    sof = 1'b0;
    chk("sof_drop_out_valid", out_valid == 1'b0, int'(out_valid), 0);
    exp_q.delete();
    n_cons = 0;
  endtask

  task automatic send_pixels(input int first, input int last, input bit gaps);
    for (int k = first; k <= last; k++) begin
      int budget = 0;
      pixel_in = 4'(img[k]);
      in_valid = 1'b1;
      do begin
        @(negedge clk);
        budget++;
      end while (!in_ready && budget < 200);
      if (!in_ready) begin
        n_tests++;
        n_fail++;
        $display("FAIL accept_timeout: pixel %0d not accepted, in_ready %0d", k, in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (gaps && $urandom_range(0, 2) == 0)
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_done();
    int budget = 0;
    while (!frame_done && budget < 400) begin
      @(negedge clk);
      budget++;
    end
    chk("frame_done", frame_done == 1'b1, int'(frame_done), 1);
    chk("out_count", n_cons == N, n_cons, N);
    chk("queue_empty", exp_q.size() == 0, exp_q.size(), 0);
  endtask

  task automatic run_frame(input int md, input int th, input bit gaps);
    pulse_sof(md, th);
    load_exp(md, th);
    send_pixels(0, N-1, gaps);
    wait_done();
  endtask

  // Sink backpressure: random 5-cycle low bursts when enabled.
  initial begin
    int burst = 0;
    forever begin
      @(posedge clk); #1;
      if (stall_en) begin
        if (burst > 0) begin
          out_ready = 1'b0;
          burst--;
        end else if ($urandom_range(0, 3) == 0) begin
          out_ready = 1'b0;
          burst = 4;
        end else begin
          out_ready = 1'b1;
        end
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // Single compare process: every consumed output and every stalled cycle.
  always @(negedge clk) begin : mon
    exp_t        e;
    bit          pv;
    logic [11:0] pd;
    logic [AW-1:0] pa;
    bit          pr;
    if (mon_en) begin
      if (pv && !pr)
        chk("hold_during_stall", out_valid && data_out == pd && addr == pa,
            int'({out_valid, addr, data_out}), int'({1'b1, pa, pd}));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL extra_output: addr %0d data %0h with nothing expected", addr, data_out);
        end else begin
          e = exp_q.pop_front();
          chk("output", addr == e.a && data_out == e.d,
              int'({addr, data_out}), int'({e.a, e.d}));
          got[addr] = data_out;
          n_cons++;
          if (addr >= AW'(N-W-1))
            chk("flush_in_ready_low", in_ready == 1'b0, int'(in_ready), 0);
        end
      end
      pv = out_valid;
      pr = out_ready;
      pd = data_out;
      pa = addr;
    end else begin
      pv = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", n_tests);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int diffs;
    mode = 2'd1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", in_ready == 1'b0, int'(in_ready), 0);
    chk("reset_out_valid", out_valid == 1'b0, int'(out_valid), 0);
    chk("reset_data_out", data_out == 12'h000, int'(data_out), 0);
    chk("reset_addr", addr == '0, int'(addr), 0);
    chk("reset_frame_done", frame_done == 1'b0, int'(frame_done), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("in_ready_before_first_clock", in_ready == 1'b0, int'(in_ready), 0);
    @(negedge clk);
    chk("in_ready_after_first_clock", in_ready == 1'b1, int'(in_ready), 1);
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Flat image, mode 1.
    set_flat(5);
    run_frame(1, 0, 1'b0);
    chk("flat_corner", got[0] == 12'h333, int'(got[0]), 'h333);
    chk("flat_interior", got[9] == 12'h000, int'(got[9]), 0);

    // DONE ignores further input until sof.
    pixel_in = 4'hF;
    in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("done_ignores_input", !in_ready && frame_done && !out_valid,
          int'({in_ready, frame_done, out_valid}), 'b010);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;

    // Vertical step, binary threshold.
    set_step();
    run_frame(0, 8, 1'b0);
    chk("step_bin_c3", got[W+3] == 12'hFFF, int'(got[W+3]), 'hFFF);
    chk("step_bin_c4", got[W+4] == 12'hFFF, int'(got[W+4]), 'hFFF);
    chk("step_bin_c0", got[W+0] == 12'h000, int'(got[W+0]), 0);
    chk("step_bin_c2", got[2*W+2] == 12'h000, int'(got[2*W+2]), 0);
    for (int k = 0; k < N; k++) got_ref[k] = got[k];

    // Same frame with output backpressure and input gaps.
    stall_en = 1'b1;
    run_frame(0, 8, 1'b1);
    stall_en = 1'b0;
    diffs = 0;
    for (int k = 0; k < N; k++) if (got[k] !== got_ref[k]) diffs++;
    chk("stalled_equals_clean", diffs == 0, diffs, 0);

    // Step image, |gy| only.
    run_frame(3, 0, 1'b0);
    chk("gy_row0_c4", got[4] == 12'h555, int'(got[4]), 'h555);
    chk("gy_row0_c5", got[5] == 12'h777, int'(got[5]), 'h777);
    chk("gy_interior", got[W+4] == 12'h000, int'(got[W+4]), 0);

    // Abort a frame with sof after 20 accepts, then a fresh frame.
    set_flat(5);
    pulse_sof(1, 0);
    load_exp(1, 0);
    send_pixels(0, 19, 1'b0);
    set_step();
    run_frame(1, 0, 1'b0);
    chk("restart_step_c4", got[W+4] == 12'h777, int'(got[W+4]), 'h777);
    chk("restart_step_c0", got[W+0] == 12'h000, int'(got[W+0]), 0);

    // Asynchronous reset mid-frame.
    set_flat(5);
    pulse_sof(2, 0);
    load_exp(2, 0);
    send_pixels(0, 9, 1'b0);
    #3;
    mon_en = 1'b0;
    reset = 1'b0;
    #1;
    chk("async_reset_out_valid", out_valid == 1'b0, int'(out_valid), 0);
    chk("async_reset_in_ready", in_ready == 1'b0, int'(in_ready), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    mon_en = 1'b1;
    run_frame(2, 0, 1'b0);
    chk("recovered_gx_corner", got[0] == 12'h111, int'(got[0]), 'h111);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/edge_stream.md
# edge_stream

Streaming 3x3 Sobel edge detector for the camera-to-VGA pixel path. It consumes one greyscale pixel per accepted handshake in raster order and keeps two line buffers plus a 3x3 window. It emits one 12-bit colour pixel per input position, with an address, in the same raster order. It generalises our fixed 640x480, 4-bit detector in four ways: parametrised geometry and pixel width, selectable output mode, valid/ready backpressure on both sides, and an explicit frame restart.

## Interface
- WIDTH, 640: pixels per row, at least 3.
- HEIGHT, 480: rows per frame, at least 2.
- PIX_W, 4: input pixel width; PIX_W+3 >= 4 required.
- ADDR_W, $clog2(WIDTH*HEIGHT): output address width.
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low.
- sof  in  1  synchronous start-of-frame pulse.
- pixel_in  in  PIX_W  input pixel, unsigned.
- in_valid  in  1  pixel_in valid.
- in_ready  out  1  block accepts pixel_in this cycle.
- mode  in  2  0 binary threshold, 1 |gx|+|gy|, 2 |gx|, 3 |gy|.
- thresh  in  PIX_W+3  unsigned threshold used by mode 0.
- data_out  out  12  {R,G,B}, 4 bits per channel.
- out_valid  out  1  data_out/addr valid.
- out_ready  in  1  sink consumes data_out this cycle.
- addr  out  ADDR_W  raster index of data_out.
- frame_done  out  1  high once all WIDTH*HEIGHT outputs have been consumed.

## Operation
- Accept: in_valid && in_ready. Consume: out_valid && out_ready.
- Input index i counts accepted pixels from 0 to WIDTH*HEIGHT-1. Output index o = i-(WIDTH+1).
- Window for output (r,c) covers rows r-1..r+1 and columns c-1..c+1. Any position outside the frame reads as 0; there is no wrap across row or frame boundaries.
- Gradients:
  - gx = (right column) − (left column), column weights 1,2,1.
  - gy = (bottom row) − (top row), row weights 1,2,1.
  - Both are signed, PIX_W+4 bits. No overflow is possible.
- Magnitude m, PIX_W+3 bits, unsigned:
  - mode 1: |gx|+|gy|
  - mode 2: |gx|
  - mode 3: |gy|
- Modes 1-3: channel = m >> (PIX_W-1); data_out = {channel, channel, channel}.
- Mode 0: data_out = 12'hFFF if |gx|>thresh or |gy|>thresh, otherwise 12'h000. Comparison is strict.
- mode and thresh are latched at reset release, on sof, and on leaving DONE. They are constant for the whole frame.
- States:
  - RUN: accepts input. Each accepted pixel with i >= WIDTH+1 loads one output.
  - RUN → FLUSH: after pixel i = WIDTH*HEIGHT-1 is accepted.
  - FLUSH: in_ready=0. Injects an internal zero pixel whenever the output register is free, producing the remaining WIDTH+1 outputs.
  - FLUSH → DONE: when output WIDTH*HEIGHT-1 is consumed.
  - DONE: in_ready=0, frame_done=1.
  - DONE → RUN: only on sof.
- sof in any state:
  - Next cycle: counters cleared, state RUN, out_valid=0. Any pending output is dropped.
  - sof together with an accept: that pixel is i=0 of the new frame.
- Reset asserted mid-frame: all state clears immediately. Line buffer contents are don't-care.

## Timing
- Reset values: in_ready=0, data_out=0, out_valid=0, addr=0, frame_done=0, state RUN. in_ready rises on the first clock after reset release.
- in_ready = (state==RUN) && (!out_valid || out_ready). This gives full throughput: 1 pixel/clock with no bubbles.
- Latency:
  - Output o is registered on the edge that accepts input o+WIDTH+1.
  - out_valid is high the following cycle.
  - FLUSH outputs take 1 cycle each while out_ready is held high.
- Ordering: addr is strictly increasing, 0..WIDTH*HEIGHT-1, with no gaps or duplicates.
- While out_valid && !out_ready, data_out and addr hold stable.
- in_valid gaps stall the pipeline only; results are unaffected.

## Test plan
- Flat image, WIDTH=8, HEIGHT=4, all pixels 5, mode 1 -> output (0,0) = 12'h333 (gx=15, gy=15, m=30); all interior outputs 12'h000.
- Vertical step, 8x4: columns 0-3 = 0, columns 4-7 = 15, mode 0, thresh=8 -> rows 1-2: columns 3,4 = 12'hFFF (|gx|=60), columns 0-2 = 12'h000.
- Same 8x4 image, out_ready toggled randomly with 5-cycle low bursts and in_valid with random gaps -> exactly 32 outputs, addr 0..31 in order, bit-identical to the unstalled run, data held during stalls.
- End of frame: in_valid held low after pixel 31 -> 9 flush outputs (addr 23..31) emitted with in_ready=0, then frame_done=1; further in_valid ignored until sof.
- sof pulsed after 20 accepts, then a fresh 8x4 frame -> out_valid drops the next cycle, addr restarts at 0, new frame output correct. Separately, reset asserted asynchronously mid-frame -> out_valid and in_ready go to 0 immediately.
- mode=3 applied to the vertical-step image -> interior outputs 12'h000; row-0 outputs at columns 4-7 nonzero (gy from zero padding).
